// File: rtl/uart_rx_buf.sv
// Receive buffer behind uart_sat: captures each ready byte into a FWFT FIFO,
// drives a hysteretic RTS stop request and counts bytes dropped on overflow.
module uart_rx_buf #(
    parameter int DEPTH        = 16,
    parameter int RTS_HI       = 12,
    parameter int RTS_LO       = 4,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_rdy,
    output logic                       clr_rdy,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       rts_stop,
    output logic [7:0]                 drop_cnt,
    input  logic                       clr_stat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] HI_LVL   = CW'(RTS_HI);
    localparam logic [CW-1:0] LO_LVL   = CW'(RTS_LO);

    typedef enum logic {IDLE, WAIT_CLR} state_t;
    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          clr_rdy_q, clr_rdy_d;
    logic          rts_q, rts_d;
    logic [7:0]    drop_q, drop_d;
    logic          full, wr_en, pop, drop;

    // Full is judged on the registered level only; a same-cycle pop never
    // makes room for a write.
    assign full    = (count_q == FULL_LVL);
    assign m_valid = (count_q != '0);
    assign pop     = m_valid & m_ready;

    always_comb begin
        state_d   = state_q;
        clr_rdy_d = 1'b0;
        wr_en     = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    if (!full) begin
                        wr_en     = 1'b1;
                        clr_rdy_d = 1'b1;
                        state_d   = WAIT_CLR;
                    end else if (DROP_ON_FULL) begin
                        drop      = 1'b1;
                        clr_rdy_d = 1'b1;
                        state_d   = WAIT_CLR;
                    end
                end
            end
            // Wait for uart_sat to lower rx_rdy so a byte is never taken twice.
            WAIT_CLR: begin
                if (!rx_rdy) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rts_d = rts_q;
        if (count_d >= HI_LVL)      rts_d = 1'b1;
        else if (count_d <= LO_LVL) rts_d = 1'b0;

        drop_d = drop_q;
        if (clr_stat)                     drop_d = 8'd0;
        else if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clr_rdy_q <= 1'b0;
            rts_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            clr_rdy_q <= clr_rdy_d;
            rts_q     <= rts_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= rx_data;
    end

    assign m_data   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign clr_rdy  = clr_rdy_q;
    assign rts_stop = rts_q;
    assign drop_cnt = drop_q;

endmodule
